// File: rtl/uart_bus_pkg.sv
// Shared constants for the UART CPU-side port: register map, status bit positions
// and the transmit sequencer state encoding.
package uart_bus_pkg;
   localparam logic [1:0] REG_DATA = 2'd0;
   localparam logic [1:0] REG_STAT = 2'd1;
   localparam logic [1:0] REG_CTRL = 2'd2;

   localparam int ST_RX_AVAIL   = 0;
   localparam int ST_TX_SPACE   = 1;
   localparam int ST_RX_OVERRUN = 2;
   localparam int ST_RX_FERR    = 3;
   localparam int ST_TX_BUSY    = 4;
   localparam int ST_TX_DROP    = 5;

   localparam int CTRL_RX_IE = 0;
   localparam int CTRL_TX_IE = 1;

   typedef enum logic [1:0] {
      TXF_IDLE       = 2'd0,
      TXF_WAIT_START = 2'd1,
      TXF_WAIT_DONE  = 2'd2
   } tx_state_e;
endpackage

// File: rtl/uart_bus_if_fifo.sv
// Show-ahead synchronous FIFO; a push while full is accepted only when a pop
// frees the slot in the same cycle.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             empty,
   output logic             full
);
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW:0]      count_q, count_d;
   logic             do_push, do_pop;

   assign empty   = (count_q == '0);
   assign full    = (count_q == (AW+1)'(DEPTH));
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign dout    = mem_q[rd_ptr_q];

   always_comb begin
      rd_ptr_d = rd_ptr_q + AW'(do_pop);
      wr_ptr_d = wr_ptr_q + AW'(do_push);
      count_d  = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset; occupancy is tracked by count_q alone.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= din;
   end
endmodule

// File: rtl/uart_bus_if.sv
// CPU I/O port front end for the UART: RX/TX FIFOs, status/control registers,
// transmit sequencer and level interrupt.
//   state          | meaning
//   TXF_IDLE       | waiting for a queued byte and an idle transmitter
//   TXF_WAIT_START | byte launched, waiting for the UART to report busy
//   TXF_WAIT_DONE  | UART sending, waiting for busy to drop
module uart_bus_if
   import uart_bus_pkg::*;
#(
   parameter int FIFO_DEPTH = 16,
   parameter int FIFO_AW    = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       io_sel,
   input  logic [1:0] io_addr,
   input  logic       io_rd,
   input  logic       io_wr,
   input  logic [7:0] io_wdata,
   output logic [7:0] io_rdata,
   output logic       irq,
   input  logic       u_received,
   input  logic [7:0] u_rx_byte,
   input  logic       u_recv_error,
   input  logic       u_is_transmitting,
   output logic       u_transmit,
   output logic [7:0] u_tx_byte
);
   tx_state_e  state_q, state_d;
   logic [7:0] rdata_q, rdata_d;
   logic [7:0] tx_byte_q, tx_byte_d;
   logic       transmit_q, transmit_d;
   logic       irq_q, irq_d;
   logic [1:0] ctrl_q, ctrl_d;
   logic       ovr_q, ovr_d, ferr_q, ferr_d, drop_q, drop_d;

   logic       rd_en, wr_en, stat_rd, tx_wr;
   logic       rx_pop, rx_empty, rx_full, tx_push, tx_pop, tx_empty, tx_full;
   logic [7:0] rx_dout, tx_dout, status;

   assign rd_en   = io_sel & io_rd;
   assign wr_en   = io_sel & io_wr;
   assign stat_rd = rd_en & (io_addr == REG_STAT);
   assign rx_pop  = rd_en & (io_addr == REG_DATA) & ~rx_empty;
   assign tx_wr   = wr_en & (io_addr == REG_DATA);
   assign tx_push = tx_wr & ~tx_full;

   sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH), .AW(FIFO_AW)) u_rx_fifo (
      .clk(clk), .rst(rst), .push(u_received), .pop(rx_pop), .din(u_rx_byte),
      .dout(rx_dout), .empty(rx_empty), .full(rx_full)
   );

   sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH), .AW(FIFO_AW)) u_tx_fifo (
      .clk(clk), .rst(rst), .push(tx_push), .pop(tx_pop), .din(io_wdata),
      .dout(tx_dout), .empty(tx_empty), .full(tx_full)
   );

   always_comb begin
      status                = '0;
      status[ST_RX_AVAIL]   = ~rx_empty;
      status[ST_TX_SPACE]   = ~tx_full;
      status[ST_RX_OVERRUN] = ovr_q;
      status[ST_RX_FERR]    = ferr_q;
      status[ST_TX_BUSY]    = (state_q != TXF_IDLE) | ~tx_empty;
      status[ST_TX_DROP]    = drop_q;
   end

   always_comb begin
      state_d    = state_q;
      tx_pop     = 1'b0;
      transmit_d = 1'b0;
      tx_byte_d  = tx_byte_q;
      unique case (state_q)
         TXF_IDLE: begin
            if (!tx_empty && !u_is_transmitting) begin
               tx_pop     = 1'b1;
               tx_byte_d  = tx_dout;
               transmit_d = 1'b1;
               state_d    = TXF_WAIT_START;
            end
         end
         TXF_WAIT_START: if (u_is_transmitting) state_d = TXF_WAIT_DONE;
         TXF_WAIT_DONE:  if (!u_is_transmitting) state_d = TXF_IDLE;
         default:        state_d = TXF_IDLE;
      endcase
   end

   // A set event in the same cycle as a status read beats the read-clear.
   always_comb begin
      ovr_d  = (u_received & rx_full & ~rx_pop) | (ovr_q & ~stat_rd);
      ferr_d = u_recv_error | (ferr_q & ~stat_rd);
      drop_d = (tx_wr & tx_full) | (drop_q & ~stat_rd);
      ctrl_d = (wr_en && io_addr == REG_CTRL) ? io_wdata[1:0] : ctrl_q;
      irq_d  = (ctrl_q[CTRL_RX_IE] & ~rx_empty) |
               (ctrl_q[CTRL_TX_IE] & tx_empty & (state_q == TXF_IDLE));
      rdata_d = rdata_q;
      if (rd_en) begin
         unique case (io_addr)
            REG_DATA: rdata_d = rx_empty ? 8'h00 : rx_dout;
            REG_STAT: rdata_d = status;
            REG_CTRL: rdata_d = {6'b0, ctrl_q};
            default:  rdata_d = 8'h00;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= TXF_IDLE;
         rdata_q    <= '0;
         tx_byte_q  <= '0;
         transmit_q <= 1'b0;
         irq_q      <= 1'b0;
         ctrl_q     <= '0;
         ovr_q      <= 1'b0;
         ferr_q     <= 1'b0;
         drop_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         rdata_q    <= rdata_d;
         tx_byte_q  <= tx_byte_d;
         transmit_q <= transmit_d;
         irq_q      <= irq_d;
         ctrl_q     <= ctrl_d;
         ovr_q      <= ovr_d;
         ferr_q     <= ferr_d;
         drop_q     <= drop_d;
      end
   end

   assign io_rdata   = rdata_q;
   assign irq        = irq_q;
   assign u_transmit = transmit_q;
   assign u_tx_byte  = tx_byte_q;
endmodule

// File: tb/tb_uart_bus_if.sv
// Randomised self-checking bench for uart_bus_if with a queue-based reference
// model of the register/FIFO behaviour and a simple UART transmitter model.
module tb_uart_bus_if;
   localparam int DEPTH = 16;
   localparam int BUSY  = 10;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       io_sel = 1'b0, io_rd = 1'b0, io_wr = 1'b0;
   logic [1:0] io_addr = 2'd0;
   logic [7:0] io_wdata = 8'h00;
   logic [7:0] io_rdata;
   logic       irq;
   logic       u_received = 1'b0, u_recv_error = 1'b0;
   logic [7:0] u_rx_byte = 8'h00;
   logic       u_is_transmitting;
   logic       u_transmit;
   logic [7:0] u_tx_byte;

   logic       busy_m = 1'b0, force_busy = 1'b0;
   assign u_is_transmitting = busy_m | force_busy;

   uart_bus_if #(.FIFO_DEPTH(16), .FIFO_AW(4)) dut (
      .clk(clk), .rst(rst), .io_sel(io_sel), .io_addr(io_addr), .io_rd(io_rd),
      .io_wr(io_wr), .io_wdata(io_wdata), .io_rdata(io_rdata), .irq(irq),
      .u_received(u_received), .u_rx_byte(u_rx_byte), .u_recv_error(u_recv_error),
      .u_is_transmitting(u_is_transmitting), .u_transmit(u_transmit),
      .u_tx_byte(u_tx_byte)
   );

   always #5 clk = ~clk;

   int n_cmp = 0, n_err = 0;
   logic [7:0] rx_ref[$], tx_ref[$], tx_obs[$];
   bit         ovr_r, ferr_r, drop_r;
   logic [1:0] ctrl_ref;
   bit         active = 1'b0, prev_tx = 1'b0;
   int         bcnt = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // UART transmitter model: busy for BUSY cycles after each launch pulse.
   initial begin
      forever begin
         @(negedge clk);
         if (rst) begin
            busy_m = 1'b0; active = 1'b0; prev_tx = 1'b0; bcnt = 0;
         end else begin
            if (u_transmit) begin
               chk("launch_while_uart_busy", {prev_tx, active}, 0);
               tx_obs.push_back(u_tx_byte);
               active = 1'b1; bcnt = 0;
            end else if (active) begin
               bcnt++;
               if (bcnt == 1) busy_m = 1'b1;
               else if (bcnt == BUSY + 1) begin busy_m = 1'b0; active = 1'b0; end
            end
            prev_tx = u_transmit;
         end
      end
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic rd(input logic [1:0] a, output logic [7:0] d);
      io_sel = 1; io_rd = 1; io_addr = a;
      tick();
      io_sel = 0; io_rd = 0;
      d = io_rdata;
   endtask

   task automatic wr(input logic [1:0] a, input logic [7:0] d);
      io_sel = 1; io_wr = 1; io_addr = a; io_wdata = d;
      tick();
      io_sel = 0; io_wr = 0;
   endtask

   task automatic inject(input logic [7:0] b);
      u_received = 1; u_rx_byte = b;
      tick();
      u_received = 0;
      if (rx_ref.size() == DEPTH) ovr_r = 1; else rx_ref.push_back(b);
   endtask

   function automatic logic [7:0] stat_exp(input bit space, input bit busy);
      return {2'b00, drop_r, busy, ferr_r, ovr_r, space, rx_ref.size() != 0};
   endfunction

   task automatic rd_stat(input string tag, input logic [7:0] mask, input bit space, input bit busy);
      logic [7:0] d;
      rd(2'd1, d);
      chk(tag, d & mask, stat_exp(space, busy) & mask);
      ovr_r = 0; ferr_r = 0; drop_r = 0;
   endtask

   task automatic rd_data(input string tag);
      logic [7:0] d, e;
      e = (rx_ref.size() != 0) ? rx_ref.pop_front() : 8'h00;
      rd(2'd0, d);
      chk(tag, d, e);
   endtask

   task automatic tx_drain_check(input string tag);
      int i;
      for (i = 0; i < 2000; i++) begin
         if (tx_obs.size() == tx_ref.size() && !active && !u_transmit) break;
         tick();
      end
      chk({tag, "_timeout"}, i < 2000, 1);
      repeat (4) tick();
      chk({tag, "_count"}, tx_obs.size(), tx_ref.size());
      while (tx_ref.size() != 0 && tx_obs.size() != 0)
         chk({tag, "_byte"}, tx_obs.pop_front(), tx_ref.pop_front());
      tx_ref.delete(); tx_obs.delete();
   endtask

   initial begin
      logic [7:0] d;
      int n, i;
      ovr_r = 0; ferr_r = 0; drop_r = 0; ctrl_ref = 2'b00;
      repeat (3) tick();
      chk("rst_rdata", io_rdata, 8'h00);
      chk("rst_irq", irq, 0);
      chk("rst_transmit", u_transmit, 0);
      chk("rst_tx_byte", u_tx_byte, 8'h00);
      rst = 0;
      tick();
      rd_stat("rst_status", 8'hFF, 1, 0);
      rd(2'd2, d); chk("rst_ctrl", d, 8'h00);

      // TX latency and back-to-back launch
      wr(2'd0, 8'h41); tx_ref.push_back(8'h41);
      chk("tx_not_early", u_transmit, 0);
      wr(2'd0, 8'h42); tx_ref.push_back(8'h42);
      chk("tx_latency_pulse", u_transmit, 1);
      chk("tx_latency_byte", u_tx_byte, 8'h41);
      tx_drain_check("tx_two");
      rd_stat("tx_done_status", 8'hFF, 1, 0);

      // RX basic
      inject(8'h10); inject(8'h20); inject(8'h30);
      repeat (4) rd_data("rx_three");
      rd_stat("rx_three_status", 8'hFF, 1, 0);

      // RX overrun
      for (i = 0; i < 17; i++) inject(8'h60 + 8'(i));
      rd_stat("ovr_status1", 8'hFF, 1, 0);
      rd_stat("ovr_status2", 8'hFF, 1, 0);
      for (i = 0; i < 17; i++) rd_data("ovr_drain");

      // Framing error
      inject(8'h77);
      u_recv_error = 1; tick(); u_recv_error = 0; ferr_r = 1;
      rd_stat("ferr_status1", 8'hFF, 1, 0);
      rd_stat("ferr_status2", 8'hFF, 1, 0);
      rd_data("ferr_data"); rd_data("ferr_empty");

      // Interrupts
      wr(2'd2, 8'h01); ctrl_ref = 2'b01;
      inject(8'h55); tick();
      chk("irq_rx_rise", irq, 1);
      rd_data("irq_data");
      tick();
      chk("irq_rx_fall", irq, 0);
      wr(2'd2, 8'hFF); ctrl_ref = 2'b11;
      rd(2'd2, d); chk("ctrl_mask", d, 8'h03);
      tick();
      chk("irq_tx_idle", irq, 1);
      wr(2'd2, 8'h00); ctrl_ref = 2'b00;
      wr(2'd3, 8'hFF); rd(2'd3, d); chk("addr3_read", d, 8'h00);
      rd(2'd2, d); chk("addr3_no_write", d, 8'h00);

      // Full RX with simultaneous push and pop
      for (i = 0; i < 16; i++) inject(8'h80 + 8'(i));
      io_sel = 1; io_rd = 1; io_addr = 2'd0; u_received = 1; u_rx_byte = 8'hEE;
      tick();
      io_sel = 0; io_rd = 0; u_received = 0;
      chk("full_pushpop_data", io_rdata, rx_ref.pop_front());
      rx_ref.push_back(8'hEE);
      rd_stat("full_pushpop_status", 8'hFF, 1, 0);
      for (i = 0; i < 16; i++) rd_data("full_pushpop_drain");

      // TX full: 17th write dropped while transmitter held busy
      force_busy = 1;
      for (i = 0; i < 17; i++) begin
         wr(2'd0, 8'hA0 + 8'(i));
         if (i < 16) tx_ref.push_back(8'hA0 + 8'(i)); else drop_r = 1;
      end
      rd_stat("tx_drop_status1", 8'hFF, 0, 1);
      rd_stat("tx_drop_status2", 8'hFF, 0, 1);
      force_busy = 0;
      tx_drain_check("tx_full");

      // Reset mid-transmission
      wr(2'd2, 8'h03);
      for (i = 0; i < 5; i++) wr(2'd0, 8'hC0 + 8'(i));
      for (i = 0; i < 200 && tx_obs.size() < 2; i++) tick();
      chk("rst_mid_started", tx_obs.size() >= 2, 1);
      repeat (3) tick();
      rst = 1; tick(); tick(); rst = 0;
      n = tx_obs.size();
      repeat (80) tick();
      chk("rst_mid_no_tx", tx_obs.size(), n);
      tx_ref.delete(); tx_obs.delete();
      rx_ref.delete(); ovr_r = 0; ferr_r = 0; drop_r = 0; ctrl_ref = 2'b00;
      rd_stat("rst_mid_status", 8'hFF, 1, 0);
      rd(2'd2, d); chk("rst_mid_ctrl", d, 8'h00);

      // Randomised traffic
      for (int it = 0; it < 300; it++) begin
         logic [7:0] b;
         b = 8'($urandom);
         case ($urandom_range(0, 9))
            0, 1, 2: inject(b);
            3: begin u_recv_error = 1; tick(); u_recv_error = 0; ferr_r = 1; end
            4, 5: rd_data("rnd_data");
            6: rd_stat("rnd_status", 8'h2D, 1, 0);
            7: begin wr(2'd2, b); ctrl_ref = b[1:0]; end
            8: begin
               if (b[7]) begin rd(2'd2, d); chk("rnd_ctrl", d, {6'b0, ctrl_ref}); end
               else if (b[6]) begin rd(2'd3, d); chk("rnd_addr3", d, 8'h00); end
               else wr(2'd3, b);
            end
            default: if (tx_ref.size() - tx_obs.size() < 8) begin
               wr(2'd0, b); tx_ref.push_back(b);
            end
         endcase
         if (!ctrl_ref[1]) begin
            tick();
            chk("rnd_irq", irq, ctrl_ref[0] & (rx_ref.size() != 0));
         end
      end
      tx_drain_check("rnd_tx");
      while (rx_ref.size() != 0) rd_data("rnd_final_drain");
      rd_data("rnd_final_empty");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
